ifc_triplet_buffer: RTL and testbench

- Sequential consumer stage directly downstream of the interface-driven producer (M).
- Accepts the producer's three DATA_W lanes (x, y, z) as one beat under a valid/ready handshake.
- Buffers beats in a small FIFO and presents them as o_a/o_b/o_c, in place of the top-level pass-through.
- Also runs a lane-consistency check (y must equal ~x) and counts accepted beats.

---
 rtl/ifc_triplet_pkg.sv | 17 +
 rtl/ifc_triplet_fifo.sv | 70 +++++++
 rtl/ifc_triplet_buffer.sv | 81 ++++++++
 tb/tb_ifc_triplet_buffer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifc_triplet_pkg.sv
// Shared types for the triplet buffer: the {x,y,z} beat payload and the lane-consistency rule.
package ifc_triplet_pkg;

  localparam int unsigned DATA_W = 8;

  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] z;
  } triplet_t;

  // Lane y is expected to carry the bitwise complement of lane x.
  function automatic logic compl_ok(input triplet_t t);
    return (t.y == ~t.x);
  endfunction

endpackage

// File: rtl/ifc_triplet_fifo.sv
// Power-of-two FIFO holding flattened beats; full/empty are registered so the
// handshake flags never depend combinationally on the consumer.
module ifc_triplet_fifo
  import ifc_triplet_pkg::*;
#(
  parameter int unsigned W     = 24,
  parameter int unsigned DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [OCC_W-1:0] w_occ_nxt;

  assign w_push = i_push & ~r_full;
  assign w_pop  = i_pop & ~r_empty;

  always_comb begin
    w_occ_nxt = r_occ;
    unique case ({w_push, w_pop})
      2'b10:   w_occ_nxt = r_occ + OCC_W'(1);
      2'b01:   w_occ_nxt = r_occ - OCC_W'(1);
      default: w_occ_nxt = r_occ;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_occ   <= w_occ_nxt;
      r_full  <= (w_occ_nxt == OCC_W'(DEPTH));
      r_empty <= (w_occ_nxt == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/ifc_triplet_buffer.sv
// Consumer stage for the x/y/z producer: buffers beats, masks the head onto
// o_a/o_b/o_c, flags y != ~x violations and counts accepted beats.
module ifc_triplet_buffer #(
  parameter int unsigned DATA_W      = ifc_triplet_pkg::DATA_W,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned CHECK_COMPL = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_x,
  input  logic [DATA_W-1:0] i_y,
  input  logic [DATA_W-1:0] i_z,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b,
  output logic [DATA_W-1:0] o_c,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_count
);

  import ifc_triplet_pkg::*;

  localparam int unsigned BEAT_W = 3 * DATA_W;
  localparam logic        CHK_EN = (CHECK_COMPL != 0);

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_compl_ok;
  logic [BEAT_W-1:0] w_head;
  logic              r_err;
  logic [CNT_W-1:0]  r_count;

  assign w_push = i_valid & ~w_full;
  assign w_pop  = ~w_empty & i_ready;

  ifc_triplet_fifo #(
    .W     (BEAT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({i_x, i_y, i_z}),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // The packaged beat type only exists at the package lane width.
  if (DATA_W == ifc_triplet_pkg::DATA_W) begin : g_pkg_chk
    assign w_compl_ok = compl_ok(triplet_t'({i_x, i_y, i_z}));
  end else begin : g_gen_chk
    assign w_compl_ok = (i_y == ~i_x);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      if (CHK_EN && w_push && !w_compl_ok) r_err <= 1'b1;
      if (w_push && (r_count != '1))       r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_ready = ~w_full;
  assign o_valid = ~w_empty;
  assign o_a     = w_empty ? '0 : w_head[BEAT_W-1 -: DATA_W];
  assign o_b     = w_empty ? '0 : w_head[2*DATA_W-1 -: DATA_W];
  assign o_c     = w_empty ? '0 : w_head[DATA_W-1 -: DATA_W];
  assign o_err   = r_err;
  assign o_count = r_count;

endmodule

// File: tb/tb_ifc_triplet_buffer.sv
// Scoreboard bench for ifc_triplet_buffer: accepted beats are queued as expected
// output, a negedge monitor pops and compares every beat the DUT hands over.
module tb_ifc_triplet_buffer;
  import ifc_triplet_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic       i_ready = 1'b0;
  logic [7:0] i_x = '0, i_y = '0, i_z = '0;
  logic       o_ready, o_valid, o_err;
  logic [7:0] o_a, o_b, o_c;
  logic [15:0] o_count;

  logic       s_valid = 1'b0;
  logic       s_ready = 1'b1;
  logic [7:0] s_x = 8'h00, s_y = 8'hFF, s_z = 8'h42;
  logic       s_ready_o, s_valid_o, s_err;
  logic [7:0] s_a, s_b, s_c;
  logic [3:0] s_count;

  int         checks = 0;
  int         errors = 0;
  triplet_t   exp_q[$];
  int         exp_count = 0;
  logic       exp_err = 1'b0;

  always #5 clk = ~clk;

  ifc_triplet_buffer #(.DATA_W(8), .DEPTH(2), .CNT_W(16), .CHECK_COMPL(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_x(i_x), .i_y(i_y), .i_z(i_z), .o_valid(o_valid), .i_ready(i_ready),
    .o_a(o_a), .o_b(o_b), .o_c(o_c), .o_err(o_err), .o_count(o_count)
  );

  ifc_triplet_buffer #(.DATA_W(8), .DEPTH(2), .CNT_W(4), .CHECK_COMPL(1)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(s_valid), .o_ready(s_ready_o),
    .i_x(s_x), .i_y(s_y), .i_z(s_z), .o_valid(s_valid_o), .i_ready(s_ready),
    .o_a(s_a), .o_b(s_b), .o_c(s_c), .o_err(s_err), .o_count(s_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat (called at posedge+1) and hold it until a handshake edge.
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                      output int waited);
    logic     rdy;
    triplet_t t;
    rdy    = 1'b0;
    waited = 0;
    i_valid = 1'b1; i_x = x; i_y = y; i_z = z;
    while (!rdy && waited < 50) begin
      @(negedge clk);
      rdy = o_ready;
      step();
      waited++;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat %0h/%0h/%0h not accepted", x, y, z);
    end else begin
      t.x = x; t.y = y; t.z = z;
      exp_q.push_back(t);
      exp_count++;
      if (y != ~x) exp_err = 1'b1;
    end
  endtask

  task automatic idle();
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    i_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
    end
    i_ready = 1'b0;
    @(negedge clk);
    check("drained_valid", 32'(o_valid), 32'd0);
    step();
  endtask

  // Monitor: every pop the DUT performs must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got %0h/%0h/%0h, required no beat", o_a, o_b, o_c);
        end else begin
          triplet_t e;
          e = exp_q.pop_front();
          check("head_a", 32'(o_a), 32'(e.x));
          check("head_b", 32'(o_b), 32'(e.y));
          check("head_c", 32'(o_c), 32'(e.z));
        end
      end else if (!o_valid) begin
        check("mask_abc", 32'({o_a, o_b, o_c}), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_abc", 32'({o_a, o_b, o_c}), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_sat_count", 32'(s_count), 32'd0);
    step();

    // Single beat, consumer stalled.
    send(8'h00, 8'hFF, 8'h5A, w);
    idle();
    @(negedge clk);
    check("single_valid", 32'(o_valid), 32'd1);
    check("single_a", 32'(o_a), 32'h00);
    check("single_b", 32'(o_b), 32'hFF);
    check("single_c", 32'(o_c), 32'h5A);
    check("single_err", 32'(o_err), 32'd0);
    check("single_count", 32'(o_count), 32'd1);
    step();
    drain();

    // Fill to full, third beat must wait for a pop.
    send(8'h01, 8'hFE, 8'h10, w);
    send(8'h02, 8'hFD, 8'h20, w);
    i_valid = 1'b1; i_x = 8'h03; i_y = 8'hFC; i_z = 8'h30;
    @(negedge clk);
    check("full_ready", 32'(o_ready), 32'd0);
    check("full_count", 32'(o_count), 32'd3);
    step();
    @(negedge clk);
    check("stall_ready", 32'(o_ready), 32'd0);
    check("stall_count", 32'(o_count), 32'd3);
    step();
    i_ready = 1'b1;
    send(8'h03, 8'hFC, 8'h30, w);
    check("stall_accept_wait", 32'(w), 32'd2);
    idle();
    drain();
    check("fill_count", 32'(o_count), 32'd4);

    // Continuous streaming, one beat per cycle.
    i_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      logic [7:0] v;
      v = 8'(n);
      send(v, ~v, v ^ 8'hA5, w);
      check("stream_wait", 32'(w), 32'd1);
    end
    idle();
    drain();
    check("stream_count", 32'(o_count), 32'd14);
    check("stream_err", 32'(o_err), 32'd0);

    // Complement violation is sticky across pops and good beats.
    send(8'h12, 8'h12, 8'h33, w);
    idle();
    @(negedge clk);
    check("viol_err", 32'(o_err), 32'd1);
    step();
    send(8'h40, 8'hBF, 8'h01, w);
    idle();
    drain();
    check("viol_sticky", 32'(o_err), 32'd1);
    check("viol_model", 32'(o_err), 32'(exp_err));
    check("viol_count", 32'(o_count), 32'd16);

    // Asynchronous reset with two beats buffered.
    send(8'hA1, 8'h5E, 8'h11, w);
    send(8'hA2, 8'h5D, 8'h22, w);
    idle();
    @(negedge clk);
    check("pre_rst_valid", 32'(o_valid), 32'd1);
    check("pre_rst_count", 32'(o_count), 32'd18);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(o_valid), 32'd0);
    check("arst_count", 32'(o_count), 32'd0);
    check("arst_err", 32'(o_err), 32'd0);
    check("arst_ready", 32'(o_ready), 32'd1);
    check("arst_abc", 32'({o_a, o_b, o_c}), 32'd0);
    exp_q.delete();
    exp_count = 0;
    exp_err = 1'b0;
    #1 rst_n = 1'b1;
    step();
    send(8'hC3, 8'h3C, 8'h77, w);
    check("post_rst_wait", 32'(w), 32'd1);
    idle();
    drain();
    check("post_rst_count", 32'(o_count), 32'(exp_count));
    check("post_rst_err", 32'(o_err), 32'd0);

    // Saturating 4-bit counter on the second instance.
    s_valid = 1'b1;
    repeat (14) step();
    check("sat_count_14", 32'(s_count), 32'd14);
    repeat (6) step();
    check("sat_count_hold", 32'(s_count), 32'hF);
    check("sat_err", 32'(s_err), 32'd0);
    s_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
